mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath (one memory for instructions and data, one ALU, instruction register) over several cycles per instruction. It sits beside the multicycle datapath, consumes `op`/`funct` from the instruction register and `zero` from the ALU, and drives every datapath enable and mux select. A `mem_ready` handshake lets memory stall fetch and data accesses.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- op  input  6  opcode from the instruction register
- funct  input  6  funct field from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current read or write
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- pcen  output  1  PC load enable
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  write data: 0 = ALUOut, 1 = Data
- regwrite  output  1  register-file write
- alusrca  output  1  ALU A: 0 = PC, 1 = A
- alusrcb  output  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU function
- state  output  4  current FSM state (debug and verification)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BRANCHEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00. When mem_ready=1: irwrite=1, PC write, go to DECODE. Otherwise hold in FETCH with irwrite=0 and no PC write.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - lw 100011 / sw 101011 → MEMADR
  - R-type 000000 → RTYPEEX
  - beq 000100 → BRANCHEX
  - addi 001000 → ADDIEX
  - j 000010 → JEX
  - any other opcode → FETCH, with no architectural write
- MEMADR: alusrca=1, alusrcb=10, add; next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
- MEMWR: iord=1, memwrite=1, held high until mem_ready=1; then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, ALU op from funct: add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111, other→010. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, sub, pcsrc=01, internal branch=1; next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add; next ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
- JEX: pcsrc=10, PC write; next FETCH.
- pcen = pcwrite | (branch & (zero XOR is_bne)).
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore (a function of `state`), except pcen, which also depends on `zero` combinationally.
- With mem_ready held at 1, cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unknown opcode 2.
- Each cycle mem_ready=0 is seen in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay stable while stalled.
- Reset asserted (asynchronously): state=FETCH immediately. While reset=0, irwrite, pcen, memwrite and regwrite are forced 0; mux selects take their FETCH values; alucontrol=010.
- Reset asserted mid-instruction abandons that instruction with no further writes. The first fetch happens on the first rising edge after reset deasserts, provided mem_ready=1.

## Configuration
- `MC_BNE_EN` defined: opcode 000101 (bne) → BRANCHEX with is_bne=1, so the branch is taken when zero=0.
- Not defined: 000101 is an unknown opcode (DECODE → FETCH), and is_bne is constant 0.

## Structure
- Shared package `mc_pkg` holds: the state enum (4-bit encoding, FETCH=0), opcode constants, funct constants, alucontrol constants and alusrcb/pcsrc select constants.
- One sub-module: the existing `aludec` (funct, aluop → alucontrol). The FSM supplies aluop as 00 = add, 01 = sub, 10 = funct.

## Test plan
- Reset pulse mid-MEMWR: state=0 and memwrite=0 during reset. After release with mem_ready=1: FETCH, then DECODE with irwrite pulsed once.
- lw (op=100011), mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1 and memtoreg=1 only in MEMWB; 5 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR: memwrite high for 4 cycles, then FETCH; total 7 cycles.
- R-type slt (funct=101010): alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in ALUWB.
- beq with zero=1 → pcen=1 in BRANCHEX; with zero=0 → pcen=0. With MC_BNE_EN, op=000101 gives the opposite result.
- Unknown op=111111: DECODE → FETCH; regwrite, memwrite and pcen stay 0 during DECODE.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU control codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPEEX  = 4'd6,
        ALUWB    = 4'd7,
        BRANCHEX = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JEX      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop (add / sub / use funct) and the R-type
// funct field onto the 3-bit ALU control code.
module aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore, pcen also follows zero) with mem_ready stalls.
// Optional: define MC_BNE_EN to decode bne (op 000101) as an inverted-sense branch.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite, branch, is_bne;
    logic       irwrite_s, memwrite_s, regwrite_s;

`ifdef MC_BNE_EN
    assign is_bne = (op == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BRANCHEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = is_bne ? BRANCHEX : FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    if (mem_ready) state_d = MEMWB;
            MEMWR:    if (mem_ready) state_d = FETCH;
            RTYPEEX:  state_d = ALUWB;
            ADDIEX:   state_d = ADDIWB;
            MEMWB, ALUWB, BRANCHEX, ADDIWB, JEX: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                alusrcb   = SRCB_FOUR;
                irwrite_s = mem_ready;
                pcwrite   = mem_ready;
            end
            DECODE:   alusrcb = SRCB_IMMSH;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            MEMRD:    iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCHEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ADDIWB:   regwrite_s = 1'b1;
            JEX: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write strobes are held off for as long as reset is low.
    assign irwrite  = irwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign regwrite = regwrite_s & reset;
    assign pcen     = reset & (pcwrite | (branch & (zero ^ is_bne)));
    assign state    = state_q;

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller; each table row is one clock cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    wire [14:0] act_ctl = {iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
                           alusrca, alusrcb, pcsrc, alucontrol};

    function automatic logic [14:0] mk(input logic io, mw, irw, pc, rd, m2r, rw, asa,
                                       input logic [1:0] asb, pcs, input logic [2:0] alu);
        return {io, mw, irw, pc, rd, m2r, rw, asa, asb, pcs, alu};
    endfunction

    task automatic add(input logic rst, input logic [5:0] o, f, input logic z, mr,
                       input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.mr = mr; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111, BNE = 6'b000101;

    logic [14:0] c_rst, c_fgo, c_fst, c_dec, c_madr, c_mrd, c_mwb, c_mwr;
    logic [14:0] c_slt, c_or, c_awb, c_br1, c_br0, c_aex, c_awb2, c_jex;

    initial begin
        c_rst  = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010);
        c_fgo  = mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010);
        c_fst  = c_rst;
        c_dec  = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
        c_madr = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        c_mrd  = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010);
        c_mwb  = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010);
        c_mwr  = mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010);
        c_slt  = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111);
        c_or   = mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001);
        c_awb  = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010);
        c_br1  = mk(0,0,0,1,0,0,0,1,2'b00,2'b01,3'b110);
        c_br0  = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
        c_aex  = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        c_awb2 = mk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010);
        c_jex  = mk(0,0,0,1,0,0,0,0,2'b00,2'b10,3'b010);

        // reset, then lw: 5 cycles
        add(0, LW, 0, 0, 1, 0, c_rst);
        add(1, LW, 0, 0, 1, 0, c_fgo);
        add(1, LW, 0, 0, 1, 1, c_dec);
        add(1, LW, 0, 0, 1, 2, c_madr);
        add(1, LW, 0, 0, 1, 3, c_mrd);
        add(1, LW, 0, 0, 1, 4, c_mwb);
        // sw with three stalled MEMWR cycles: 7 cycles
        add(1, SW, 0, 0, 1, 0, c_fgo);
        add(1, SW, 0, 0, 1, 1, c_dec);
        add(1, SW, 0, 0, 1, 2, c_madr);
        add(1, SW, 0, 0, 0, 5, c_mwr);
        add(1, SW, 0, 0, 0, 5, c_mwr);
        add(1, SW, 0, 0, 0, 5, c_mwr);
        add(1, SW, 0, 0, 1, 5, c_mwr);
        // slt
        add(1, RT, 6'b101010, 0, 1, 0, c_fgo);
        add(1, RT, 6'b101010, 0, 1, 1, c_dec);
        add(1, RT, 6'b101010, 0, 1, 6, c_slt);
        add(1, RT, 6'b101010, 0, 1, 7, c_awb);
        // or
        add(1, RT, 6'b100101, 0, 1, 0, c_fgo);
        add(1, RT, 6'b100101, 0, 1, 1, c_dec);
        add(1, RT, 6'b100101, 0, 1, 6, c_or);
        add(1, RT, 6'b100101, 0, 1, 7, c_awb);
        // beq taken / not taken
        add(1, BEQ, 0, 1, 1, 0, c_fgo);
        add(1, BEQ, 0, 1, 1, 1, c_dec);
        add(1, BEQ, 0, 1, 1, 8, c_br1);
        add(1, BEQ, 0, 0, 1, 0, c_fgo);
        add(1, BEQ, 0, 0, 1, 1, c_dec);
        add(1, BEQ, 0, 0, 1, 8, c_br0);
        // addi
        add(1, ADDI, 0, 0, 1, 0, c_fgo);
        add(1, ADDI, 0, 0, 1, 1, c_dec);
        add(1, ADDI, 0, 0, 1, 9, c_aex);
        add(1, ADDI, 0, 0, 1, 10, c_awb2);
        // j
        add(1, JMP, 0, 0, 1, 0, c_fgo);
        add(1, JMP, 0, 0, 1, 1, c_dec);
        add(1, JMP, 0, 0, 1, 11, c_jex);
        // unknown opcode: 2 cycles, no writes in DECODE
        add(1, BAD, 0, 0, 1, 0, c_fgo);
        add(1, BAD, 0, 0, 1, 1, c_dec);
        // stalled fetch, then op 000101
        add(1, BNE, 0, 0, 0, 0, c_fst);
        add(1, BNE, 0, 0, 0, 0, c_fst);
        add(1, BNE, 0, 0, 1, 0, c_fgo);
        add(1, BNE, 0, 0, 1, 1, c_dec);
`ifdef MC_BNE_EN
        add(1, BNE, 0, 0, 1, 8, c_br1);
        add(1, BNE, 0, 1, 1, 0, c_fgo);
        add(1, BNE, 0, 1, 1, 1, c_dec);
        add(1, BNE, 0, 1, 1, 8, c_br0);
`else
        add(1, BNE, 0, 0, 1, 0, c_fgo);
`endif

        reset = 1'b0; op = 0; funct = 0; zero = 0; mem_ready = 0;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
            zero = vecs[i].zero; mem_ready = vecs[i].mr;
            @(negedge clk);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
            @(posedge clk); #1;
        end

        // Reset pulse in the middle of a stalled sw write
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pre_state", 32'(state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; op = SW; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        #1 chk("mw_state", 32'(state), 32'd5);
        chk("mw_memwrite", 32'(memwrite), 32'd1);
        #1 reset = 1'b0;
        #1 chk("async_state", 32'(state), 32'd0);
        chk("async_memwrite", 32'(memwrite), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("inrst_state", 32'(state), 32'd0);
        chk("inrst_irwrite", 32'(irwrite), 32'd0);
        chk("inrst_pcen", 32'(pcen), 32'd0);
        chk("inrst_alu", 32'(alucontrol), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rel_state", 32'(state), 32'd0);
        chk("rel_irwrite", 32'(irwrite), 32'd1);
        @(posedge clk); #1;
        chk("rel_dec_state", 32'(state), 32'd1);
        chk("rel_dec_irwrite", 32'(irwrite), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
